// File: rtl/dof_ex_stall_pipe_pkg.sv
// pipe_pkg: shared definitions for the DOF->EX pipeline slice.
//   state_t  : pipeline control FSM states (RUN / STALL)
//   DA_W/FS_W: destination-address and function-select field widths
//   NOP_*    : field values loaded into EX when a bubble is injected
package pipe_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam int unsigned DA_W = 3;
    localparam int unsigned FS_W = 5;

    localparam logic [FS_W-1:0] NOP_FS = 5'b0;
    localparam logic [DA_W-1:0] NOP_DA = 3'b0;

endpackage

// File: rtl/dof_ex_stall_pipe_sat_counter.sv
// sat_counter: saturating up-counter, used for the stall statistics.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (clears q)
//   inc   : count enable, one increment per edge
//   q     : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/dof_ex_stall_pipe.sv
// dof_ex_stall_pipe: DOF->EX pipeline register with hazard stall and
// branch-flush bubble control, plus a saturating bubble counter.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   DHS_O                 : data hazard flag from the stall detector
//   BR_FLUSH              : taken branch in EX, DOF slot is wrong-path
//   RW_D..B_D             : decoded DOF-stage control and operands
//   RW_E..B_E             : registered EX-stage copies
//   VALID_E               : 1 = EX holds a real instruction, 0 = bubble
//   PC_EN, IR_EN, IR_CLR  : combinational PC/IR load / IR flush controls
//   STALL_CNT             : hazard bubbles since reset, saturating
module dof_ex_stall_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             DHS_O,
    input  logic             BR_FLUSH,
    input  logic             RW_D,
    input  logic [2:0]       DA_D,
    input  logic             MD_D,
    input  logic             MW_D,
    input  logic [4:0]       FS_D,
    input  logic [WIDTH-1:0] A_D,
    input  logic [WIDTH-1:0] B_D,
    output logic             RW_E,
    output logic [2:0]       DA_E,
    output logic             MD_E,
    output logic             MW_E,
    output logic [4:0]       FS_E,
    output logic [WIDTH-1:0] A_E,
    output logic [WIDTH-1:0] B_E,
    output logic             VALID_E,
    output logic             PC_EN,
    output logic             IR_EN,
    output logic             IR_CLR,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam int unsigned REM_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    state_t           state, state_nx;
    logic [REM_W-1:0] rem, rem_nx;
    logic             capture;
    logic             stall_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // Every edge loads EX with either the DOF instruction or a bubble,
    // so the control only has to decide which one.
    always_comb begin
        state_nx  = state;
        rem_nx    = rem;
        PC_EN     = 1'b1;
        IR_EN     = 1'b1;
        IR_CLR    = 1'b0;
        capture   = 1'b0;
        stall_inc = 1'b0;

        if (BR_FLUSH) begin
            IR_CLR   = 1'b1;
            state_nx = ST_RUN;
            rem_nx   = '0;
        end else if (state == ST_STALL) begin
            PC_EN     = 1'b0;
            IR_EN     = 1'b0;
            stall_inc = 1'b1;
            rem_nx    = rem - 1'b1;
            if (rem == REM_W'(1)) begin
                state_nx = ST_RUN;
            end
        end else if (DHS_O) begin
            PC_EN     = 1'b0;
            IR_EN     = 1'b0;
            stall_inc = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_nx = ST_STALL;
                rem_nx   = REM_W'(STALL_CYCLES - 1);
            end
        end else begin
            capture = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RW_E    <= 1'b0;
            DA_E    <= NOP_DA;
            MD_E    <= 1'b0;
            MW_E    <= 1'b0;
            FS_E    <= NOP_FS;
            A_E     <= '0;
            B_E     <= '0;
            VALID_E <= 1'b0;
        end else if (capture) begin
            RW_E    <= RW_D;
            DA_E    <= DA_D;
            MD_E    <= MD_D;
            MW_E    <= MW_D;
            FS_E    <= FS_D;
            A_E     <= A_D;
            B_E     <= B_D;
            VALID_E <= 1'b1;
        end else begin
            RW_E    <= 1'b0;
            DA_E    <= NOP_DA;
            MD_E    <= 1'b0;
            MW_E    <= 1'b0;
            FS_E    <= NOP_FS;
            A_E     <= '0;
            B_E     <= '0;
            VALID_E <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (stall_inc),
        .q    (STALL_CNT)
    );

endmodule

// File: tb/tb_dof_ex_stall_pipe.sv
// Testbench for dof_ex_stall_pipe: two instances (1-bubble/16-bit counter
// and 3-bubble/4-bit counter) share one stimulus stream. A driver pushes
// expected per-cycle results from a behavioural model into a queue per
// instance; a monitor pops and compares on the falling edge.
module tb_dof_ex_stall_pipe;

    typedef struct packed {
        logic       rw;
        logic [2:0] da;
        logic       md;
        logic       mw;
        logic [4:0] fs;
        logic [7:0] a;
        logic [7:0] b;
        logic       v;
    } ex_t;

    typedef struct {
        logic pc;
        logic ir;
        logic clr;
        ex_t  ex;
        int   cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dhs = 1'b0, br = 1'b0;
    logic       rw_d = 1'b0, md_d = 1'b0, mw_d = 1'b0;
    logic [2:0] da_d = '0;
    logic [4:0] fs_d = '0;
    logic [7:0] a_d = '0, b_d = '0;

    logic       rw_e [2];
    logic [2:0] da_e [2];
    logic       md_e [2];
    logic       mw_e [2];
    logic [4:0] fs_e [2];
    logic [7:0] a_e  [2];
    logic [7:0] b_e  [2];
    logic       v_e  [2];
    logic       pc_en[2];
    logic       ir_en[2];
    logic       ir_clr[2];
    logic [15:0] cnt1;
    logic [3:0]  cnt3;

    always #5 clk = ~clk;

    dof_ex_stall_pipe #(.WIDTH(8), .STALL_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .DHS_O(dhs), .BR_FLUSH(br),
        .RW_D(rw_d), .DA_D(da_d), .MD_D(md_d), .MW_D(mw_d), .FS_D(fs_d),
        .A_D(a_d), .B_D(b_d),
        .RW_E(rw_e[0]), .DA_E(da_e[0]), .MD_E(md_e[0]), .MW_E(mw_e[0]),
        .FS_E(fs_e[0]), .A_E(a_e[0]), .B_E(b_e[0]), .VALID_E(v_e[0]),
        .PC_EN(pc_en[0]), .IR_EN(ir_en[0]), .IR_CLR(ir_clr[0]), .STALL_CNT(cnt1)
    );

    dof_ex_stall_pipe #(.WIDTH(8), .STALL_CYCLES(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .DHS_O(dhs), .BR_FLUSH(br),
        .RW_D(rw_d), .DA_D(da_d), .MD_D(md_d), .MW_D(mw_d), .FS_D(fs_d),
        .A_D(a_d), .B_D(b_d),
        .RW_E(rw_e[1]), .DA_E(da_e[1]), .MD_E(md_e[1]), .MW_E(mw_e[1]),
        .FS_E(fs_e[1]), .A_E(a_e[1]), .B_E(b_e[1]), .VALID_E(v_e[1]),
        .PC_EN(pc_en[1]), .IR_EN(ir_en[1]), .IR_CLR(ir_clr[1]), .STALL_CNT(cnt3)
    );

    // Behavioural model: bubbles still owed, saturating count, EX contents.
    int   bubbles_owed [2];
    int   m_cnt        [2];
    ex_t  m_ex         [2];
    int   per_hazard   [2] = '{1, 3};
    int   cnt_max      [2] = '{65535, 15};
    exp_t sb0[$];
    exp_t sb1[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, k, act, req, $time);
    endfunction

    function automatic ex_t dut_ex(int k);
        ex_t e;
        e = '{rw: rw_e[k], da: da_e[k], md: md_e[k], mw: mw_e[k], fs: fs_e[k],
              a: a_e[k], b: b_e[k], v: v_e[k]};
        return e;
    endfunction

    function automatic int dut_cnt(int k);
        return (k == 0) ? int'(cnt1) : int'(cnt3);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            bubbles_owed[k] = 0;
            m_cnt[k]        = 0;
            m_ex[k]         = '0;
        end
        sb0.delete();
        sb1.delete();
    endfunction

    // One cycle: drive inputs after the edge, record what should be seen
    // this cycle, then advance the model across the coming edge.
    task automatic step(input logic h, input logic f, input ex_t d);
        exp_t e;
        ex_t  in;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        dhs = h; br = f;
        rw_d = d.rw; da_d = d.da; md_d = d.md; mw_d = d.mw;
        fs_d = d.fs; a_d = d.a; b_d = d.b;
        in = d;
        in.v = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e.ex  = m_ex[k];
            e.cnt = m_cnt[k];
            if (f) begin
                e.pc = 1; e.ir = 1; e.clr = 1;
                m_ex[k] = '0;
                bubbles_owed[k] = 0;
            end else if (bubbles_owed[k] > 0 || h) begin
                e.pc = 0; e.ir = 0; e.clr = 0;
                m_ex[k] = '0;
                if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
                bubbles_owed[k] = (bubbles_owed[k] > 0) ? bubbles_owed[k] - 1
                                                       : per_hazard[k] - 1;
            end else begin
                e.pc = 1; e.ir = 1; e.clr = 0;
                m_ex[k] = in;
            end
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
    endtask

    task automatic check_reset_state(string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_ex"},  k, 32'(dut_ex(k)), 32'h0);
            chk({nm, "_cnt"}, k, 32'(dut_cnt(k)), 32'h0);
            chk({nm, "_pc"},  k, 32'(pc_en[k]), 32'h1);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        dhs = 1'b0; br = 1'b0;
        #1;
        check_reset_state("reset_async");
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 && sb0.size() > 0) || (k == 1 && sb1.size() > 0)) begin
                    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk("pc_en",     k, 32'(pc_en[k]),  32'(e.pc));
                    chk("ir_en",     k, 32'(ir_en[k]),  32'(e.ir));
                    chk("ir_clr",    k, 32'(ir_clr[k]), 32'(e.clr));
                    chk("ex_regs",   k, 32'(dut_ex(k)), 32'(e.ex));
                    chk("stall_cnt", k, 32'(dut_cnt(k)), 32'(e.cnt));
                end
            end
        end
    end

    function automatic ex_t rand_ex();
        ex_t d;
        d = ex_t'($urandom);
        d.v = 1'b0;
        return d;
    endfunction

    initial begin
        ex_t d;
        model_reset();
        #3;
        check_reset_state("reset_pre_edge");

        // normal flow
        d = '{rw: 1, da: 3'd5, md: 0, mw: 0, fs: 5'h02, a: 8'h3C, b: 8'h00, v: 0};
        step(0, 0, d);
        step(0, 0, rand_ex());
        // single hazard, held instruction then advances
        d = rand_ex();
        step(1, 0, d);
        repeat (3) step(0, 0, d);
        // hazard with DHS toggling during STALL
        d = rand_ex();
        step(1, 0, d); step(1, 0, d); step(0, 0, d); step(1, 0, d);
        repeat (3) step(0, 0, d);
        // flush together with hazard
        step(1, 1, rand_ex());
        step(0, 0, rand_ex());
        // flush in the 2nd STALL cycle
        d = rand_ex();
        step(1, 0, d); step(0, 0, d); step(0, 1, d);
        repeat (2) step(0, 0, rand_ex());
        // reset mid-STALL, released with DHS_O low
        step(1, 0, rand_ex());
        step(0, 0, rand_ex());
        do_reset();
        repeat (3) step(0, 0, rand_ex());

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(logic'($urandom_range(0, 99) < 30), logic'($urandom_range(0, 99) < 10),
                 rand_ex());
        end

        // saturation: continuous hazards drive the 4-bit counter to all-ones
        do_reset();
        repeat (25) step(1, 0, rand_ex());
        repeat (4) step(0, 0, rand_ex());

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", 0, 32'(sb0.size() + sb1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/dof_ex_stall_pipe.md
Name: dof_ex_stall_pipe

Overview:
- DOF→EX pipeline register for the pipelined MCU, with stall and bubble control.
- Captures decoded DOF-stage control and operands into the EX stage.
- Feeds RW_E and DA_E back to the data hazard stall detector; consumes its DHS_O.
- On a hazard it holds PC/IR and injects a bubble; on a taken branch it flushes the DOF slot. It also keeps a saturating stall-statistics counter.

Parameters:
- WIDTH, 8, operand datapath width (A/B buses).
- STALL_CYCLES, 1, bubbles injected per detected hazard (≥1).
- CNT_W, 16, stall-statistics counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- DHS_O  in  1  hazard flag from stall detector (1 = hazard this cycle).
- BR_FLUSH  in  1  taken branch/jump resolved in EX; DOF instruction is wrong-path.
- RW_D  in  1  DOF register-write enable.
- DA_D  in  3  DOF destination address.
- MD_D  in  1  DOF mux-D select.
- MW_D  in  1  DOF memory-write enable.
- FS_D  in  5  DOF function select.
- A_D  in  WIDTH  DOF operand A.
- B_D  in  WIDTH  DOF operand B.
- RW_E, DA_E, MD_E, MW_E, FS_E, A_E, B_E  out  matching widths  registered EX-stage copies.
- VALID_E  out  1  1 = EX holds a real instruction; 0 = bubble.
- PC_EN  out  1  PC load enable (0 = hold).
- IR_EN  out  1  IR load enable (0 = hold).
- IR_CLR  out  1  load NOP into IR next edge (flush).
- STALL_CNT  out  CNT_W  total bubble cycles since reset, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - All EX registers 0 and VALID_E=0.
  - State=RUN, remaining-bubble counter=0, STALL_CNT=0.
  - Outputs are effective immediately, without waiting for a clock edge.
- Bubble: RW_E=0, MW_E=0, DA_E=0, MD_E=0, FS_E=0, A_E=B_E=0, VALID_E=0.
- FSM states: RUN, STALL.
- Priority per cycle: BR_FLUSH > STALL state > DHS_O > normal.
- BR_FLUSH=1, in any state:
  - Next edge loads a bubble and forces RUN with counter cleared.
  - Combinationally PC_EN=1, IR_EN=1, IR_CLR=1.
  - Not counted in STALL_CNT.
- RUN, DHS_O=1:
  - Combinationally PC_EN=0, IR_EN=0, IR_CLR=0.
  - Next edge loads a bubble and increments STALL_CNT.
  - If STALL_CYCLES>1: go to STALL with counter=STALL_CYCLES-1; else stay RUN.
- STALL:
  - PC_EN=0, IR_EN=0; a bubble is loaded each edge and STALL_CNT increments.
  - Counter decrements each edge; the edge where counter==1 returns to RUN.
  - DHS_O is ignored while in STALL.
- RUN, DHS_O=0, BR_FLUSH=0:
  - PC_EN=1, IR_EN=1, IR_CLR=0.
  - Next edge captures all *_D into *_E, with VALID_E=1.
- Latency: DOF→EX is 1 cycle. A held instruction advances on the first edge where PC_EN=1.
- Combinational paths: DHS_O is computed from registered RW_E/DA_E, so the DHS_O→PC_EN path forms no loop. PC_EN, IR_EN and IR_CLR are purely combinational from state, DHS_O and BR_FLUSH.
- STALL_CNT saturates at all-ones and never wraps.
- Reset mid-STALL aborts to RUN; PC_EN=1 immediately after release if DHS_O=0.

Decomposition:
- Shared package pipe_pkg:
  - state encoding (ST_RUN, ST_STALL);
  - bubble constants (NOP_FS=5'b0, NOP_DA=3'b0);
  - field widths (DA_W=3, FS_W=5).
- One natural sub-module, sat_counter (CNT_W, inc, q), for STALL_CNT.
- EX register and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-clock → all EX outputs 0, VALID_E=0, STALL_CNT=0 before any edge; release with DHS_O=0 → PC_EN=IR_EN=1.
- Normal flow: RW_D=1, DA_D=3'd5, FS_D=5'h02, A_D=8'h3C, DHS_O=0, one edge → RW_E=1, DA_E=5, FS_E=2, A_E=8'h3C, VALID_E=1.
- Single hazard: STALL_CYCLES=1, DHS_O=1 for one cycle → PC_EN=IR_EN=0 that cycle; next edge gives a bubble (RW_E=0, VALID_E=0), STALL_CNT=1; the held instruction enters EX one edge later.
- Multi-bubble: STALL_CYCLES=3, one-cycle DHS_O pulse → exactly 3 consecutive bubbles, PC_EN=0 for 3 cycles, STALL_CNT=3; DHS_O toggling during STALL does not change this.
- Flush overrides: BR_FLUSH=1 together with DHS_O=1, and again in the 2nd STALL cycle → PC_EN=1, IR_CLR=1, bubble loaded, state RUN, STALL_CNT not incremented by the flush cycle.
- Saturation: CNT_W=4, force 20 hazard bubbles → STALL_CNT=4'hF, holds.
